// File: rtl/rx_fsrc_seq_pkg.sv
// Shared types and defaults for the RX FSRC wait-valid sequencer.
// Optional skew capture is enabled by defining RX_FSRC_SEQ_SKEW_CNT_EN.
package rx_fsrc_seq_pkg;

    localparam int unsigned SEQ_STATE_W           = 3;
    localparam int unsigned DEFAULT_TIMEOUT_WIDTH = 32;
    localparam int unsigned DEFAULT_ARM_DELAY     = 4;

    typedef enum logic [SEQ_STATE_W-1:0] {
        StIdle   = 3'd0,
        StArm    = 3'd1,
        StWait   = 3'd2,
        StLocked = 3'd3,
        StStop   = 3'd4,
        StError  = 3'd5
    } seq_state_e;

endpackage

// File: rtl/rx_fsrc_seq_link_tracker.sv
// Per-link first-valid tracker: sticky seen bit, loss detect while locked and,
// with RX_FSRC_SEQ_SKEW_CNT_EN defined, the WAIT counter value at first valid.
module rx_fsrc_seq_link_tracker
    import rx_fsrc_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_WIDTH = DEFAULT_TIMEOUT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     in_wait,
    input  logic                     in_locked,
    input  logic                     mask_bit,
    input  logic                     valid,
`ifdef RX_FSRC_SEQ_SKEW_CNT_EN
    input  logic [TIMEOUT_WIDTH-1:0] wait_cnt,
    output logic [TIMEOUT_WIDTH-1:0] lock_cycles,
`endif
    output logic                     seen,
    output logic                     seen_now,
    output logic                     lost
);

    logic seen_q;
    logic hit;

    assign hit      = in_wait & mask_bit & valid;
    assign seen_now = seen_q | (mask_bit & valid);
    assign lost     = in_locked & mask_bit & ~valid;
    assign seen     = seen_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen_q <= 1'b0;
        end else if (clear) begin
            seen_q <= 1'b0;
        end else if (hit) begin
            seen_q <= 1'b1;
        end
    end

`ifdef RX_FSRC_SEQ_SKEW_CNT_EN
    logic [TIMEOUT_WIDTH-1:0] lock_cycles_q;

    // Capture only on the first valid so later valids do not overwrite the skew.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_cycles_q <= '0;
        end else if (clear) begin
            lock_cycles_q <= '0;
        end else if (hit && !seen_q) begin
            lock_cycles_q <= wait_cnt;
        end
    end

    assign lock_cycles = lock_cycles_q;
`endif

endmodule

// File: rtl/rx_fsrc_seq_ctrl.sv
// RX FSRC capture sequencer: arms the per-link gates, waits for every masked link to
// see valid, then reports lock, timeout or loss. Skew capture: RX_FSRC_SEQ_SKEW_CNT_EN.
module rx_fsrc_seq_ctrl
    import rx_fsrc_seq_pkg::*;
#(
    parameter int unsigned NUM_LINK      = 4,
    parameter int unsigned TIMEOUT_WIDTH = DEFAULT_TIMEOUT_WIDTH,
    parameter int unsigned ARM_DELAY     = DEFAULT_ARM_DELAY
) (
    input  logic                     rx_glblclk,
    input  logic                     rx_transport_reset_gc,
    input  logic                     seq_start,
    input  logic                     seq_stop,
    input  logic [NUM_LINK-1:0]      link_mask,
    input  logic [TIMEOUT_WIDTH-1:0] timeout_cycles,
    input  logic [NUM_LINK-1:0]      link_fsrc_valid,
    output logic                     fsrc_en,
    output logic [NUM_LINK-1:0]      link_gate_reset,
    output logic                     seq_busy,
    output logic                     seq_locked,
    output logic                     seq_timeout,
    output logic                     seq_link_lost,
    output logic [NUM_LINK-1:0]      link_valid_seen,
    output logic [SEQ_STATE_W-1:0]   seq_state
`ifdef RX_FSRC_SEQ_SKEW_CNT_EN
    ,
    output logic [NUM_LINK-1:0][TIMEOUT_WIDTH-1:0] link_lock_cycles
`endif
);

    localparam int unsigned DLY_W = (ARM_DELAY > 1) ? $clog2(ARM_DELAY) : 1;
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(ARM_DELAY - 1);

    seq_state_e                state_q, state_d;
    logic [DLY_W-1:0]          dly_q, dly_d;
    logic [TIMEOUT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [NUM_LINK-1:0]       mask_q, mask_d;
    logic                      timeout_q, timeout_d;
    logic                      lost_q, lost_d;
    logic                      fsrc_en_q, busy_q, locked_q;
    logic [NUM_LINK-1:0]       gate_q;

    logic                      start_acc, stop_acc, all_seen, any_lost, timeout_hit, run_d;
    logic                      in_wait, in_locked;
    logic [NUM_LINK-1:0]       seen, seen_now, lost;

    assign in_wait   = (state_q == StWait);
    assign in_locked = (state_q == StLocked);

    // Stop beats start; a start with an empty mask is not a command at all.
    assign start_acc = seq_start && !seq_stop && (link_mask != '0) &&
                       ((state_q == StIdle) || (state_q == StError));
    assign stop_acc  = seq_stop && ((state_q == StArm) || (state_q == StWait) ||
                                    (state_q == StLocked) || (state_q == StError));

    assign all_seen    = ((seen_now & mask_q) == mask_q);
    assign any_lost    = |lost;
    assign timeout_hit = (timeout_cycles != '0) &&
                         (cnt_q == timeout_cycles - TIMEOUT_WIDTH'(1));

    for (genvar i = 0; i < NUM_LINK; i++) begin : g_link
        rx_fsrc_seq_link_tracker #(
            .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
        ) u_tracker (
            .clk         (rx_glblclk),
            .rst         (rx_transport_reset_gc),
            .clear       (start_acc),
            .in_wait     (in_wait),
            .in_locked   (in_locked),
            .mask_bit    (mask_q[i]),
            .valid       (link_fsrc_valid[i]),
`ifdef RX_FSRC_SEQ_SKEW_CNT_EN
            .wait_cnt    (cnt_q),
            .lock_cycles (link_lock_cycles[i]),
`endif
            .seen        (seen[i]),
            .seen_now    (seen_now[i]),
            .lost        (lost[i])
        );
    end

    always_comb begin
        state_d   = state_q;
        dly_d     = dly_q;
        cnt_d     = cnt_q;
        mask_d    = mask_q;
        timeout_d = timeout_q;
        lost_d    = lost_q;
        if (stop_acc) begin
            state_d = StStop;
            dly_d   = '0;
        end else if (start_acc) begin
            state_d   = StArm;
            dly_d     = '0;
            mask_d    = link_mask;
            timeout_d = 1'b0;
            lost_d    = 1'b0;
        end else begin
            case (state_q)
                StIdle, StError: ;
                StArm: begin
                    if (dly_q == DLY_LAST) begin
                        state_d = StWait;
                        cnt_d   = '0;
                    end else begin
                        dly_d = dly_q + 1'b1;
                    end
                end
                StWait: begin
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                    if (all_seen) begin
                        state_d = StLocked;
                    end else if (timeout_hit) begin
                        state_d   = StError;
                        timeout_d = 1'b1;
                    end
                end
                StLocked: begin
                    if (any_lost) begin
                        state_d = StError;
                        lost_d  = 1'b1;
                    end
                end
                StStop: begin
                    if (dly_q == DLY_LAST) begin
                        state_d = StIdle;
                    end else begin
                        dly_d = dly_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with seq_state.
    assign run_d = (state_d == StWait) || (state_d == StLocked);

    always_ff @(posedge rx_glblclk or posedge rx_transport_reset_gc) begin
        if (rx_transport_reset_gc) begin
            state_q   <= StIdle;
            dly_q     <= '0;
            cnt_q     <= '0;
            mask_q    <= '0;
            timeout_q <= 1'b0;
            lost_q    <= 1'b0;
            fsrc_en_q <= 1'b0;
            gate_q    <= '1;
            busy_q    <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            dly_q     <= dly_d;
            cnt_q     <= cnt_d;
            mask_q    <= mask_d;
            timeout_q <= timeout_d;
            lost_q    <= lost_d;
            fsrc_en_q <= run_d;
            gate_q    <= run_d ? ~mask_d : '1;
            busy_q    <= (state_d != StIdle);
            locked_q  <= (state_d == StLocked);
        end
    end

    assign fsrc_en         = fsrc_en_q;
    assign link_gate_reset = gate_q;
    assign seq_busy        = busy_q;
    assign seq_locked      = locked_q;
    assign seq_timeout     = timeout_q;
    assign seq_link_lost   = lost_q;
    assign link_valid_seen = seen;
    assign seq_state       = state_q;

endmodule

// File: tb/tb_rx_fsrc_seq_ctrl.sv
// Directed bench for rx_fsrc_seq_ctrl; checks link_lock_cycles when
// RX_FSRC_SEQ_SKEW_CNT_EN is defined.
module tb_rx_fsrc_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seq_start = 1'b0;
    logic        seq_stop = 1'b0;
    logic [3:0]  link_mask = '0;
    logic [31:0] timeout_cycles = '0;
    logic [3:0]  link_fsrc_valid = '0;
    logic        fsrc_en;
    logic [3:0]  link_gate_reset;
    logic        seq_busy, seq_locked, seq_timeout, seq_link_lost;
    logic [3:0]  link_valid_seen;
    logic [2:0]  seq_state;
`ifdef RX_FSRC_SEQ_SKEW_CNT_EN
    logic [3:0][31:0] link_lock_cycles;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rx_fsrc_seq_ctrl #(
        .NUM_LINK      (4),
        .TIMEOUT_WIDTH (32),
        .ARM_DELAY     (4)
    ) dut (
        .rx_glblclk            (clk),
        .rx_transport_reset_gc (rst),
        .seq_start             (seq_start),
        .seq_stop              (seq_stop),
        .link_mask             (link_mask),
        .timeout_cycles        (timeout_cycles),
        .link_fsrc_valid       (link_fsrc_valid),
        .fsrc_en               (fsrc_en),
        .link_gate_reset       (link_gate_reset),
        .seq_busy              (seq_busy),
        .seq_locked            (seq_locked),
        .seq_timeout           (seq_timeout),
        .seq_link_lost         (seq_link_lost),
        .link_valid_seen       (link_valid_seen),
        .seq_state             (seq_state)
`ifdef RX_FSRC_SEQ_SKEW_CNT_EN
        ,
        .link_lock_cycles      (link_lock_cycles)
`endif
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input logic [3:0] m);
        link_mask = m;
        seq_start = 1'b1;
        tick(1);
        seq_start = 1'b0;
    endtask

    task automatic test_reset;
        tick(2);
        checks++;
        if ({seq_state, fsrc_en, link_gate_reset} !== {3'd0, 1'b0, 4'hF}) begin
            errors++;
            $display("FAIL reset_core: got state=%0d en=%b gate=%b want 0 0 1111",
                     seq_state, fsrc_en, link_gate_reset);
        end
        checks++;
        if ({seq_busy, seq_locked, seq_timeout, seq_link_lost, link_valid_seen} !== 8'h00) begin
            errors++;
            $display("FAIL reset_status: got %b want 00000000",
                     {seq_busy, seq_locked, seq_timeout, seq_link_lost, link_valid_seen});
        end
        rst = 1'b0;
        tick(1);
        checks++;
        if (seq_state !== 3'd0) begin
            errors++;
            $display("FAIL reset_release: state=%0d want 0", seq_state);
        end
    endtask

    task automatic test_basic_lock;
        logic [3:0] v;
        timeout_cycles = 32'd100;
        pulse_start(4'hF);
        link_mask = 4'h0;  // later mask changes must be ignored
        checks++;
        if ({seq_state, seq_busy} !== {3'd1, 1'b1}) begin
            errors++;
            $display("FAIL lock_arm: state=%0d busy=%b want 1 1", seq_state, seq_busy);
        end
        tick(3);
        checks++;
        if (fsrc_en !== 1'b0) begin
            errors++;
            $display("FAIL lock_en_early: en=%b want 0", fsrc_en);
        end
        tick(1);
        checks++;
        if ({seq_state, fsrc_en, link_gate_reset} !== {3'd2, 1'b1, 4'h0}) begin
            errors++;
            $display("FAIL lock_wait_entry: state=%0d en=%b gate=%b want 2 1 0000",
                     seq_state, fsrc_en, link_gate_reset);
        end
        for (int k = 0; k < 10; k++) begin
            v = 4'h0;
            v[0] = (k >= 3);
            v[1] = (k >= 5);
            v[2] = (k >= 7);
            v[3] = (k >= 9);
            link_fsrc_valid = v;
            if (k == 9) begin
                checks++;
                if (seq_locked !== 1'b0) begin
                    errors++;
                    $display("FAIL lock_early: locked=%b want 0", seq_locked);
                end
            end
            tick(1);
        end
        checks++;
        if ({seq_state, seq_locked, link_valid_seen, link_gate_reset} !== {3'd3, 1'b1, 4'hF, 4'h0}) begin
            errors++;
            $display("FAIL lock_done: state=%0d locked=%b seen=%b gate=%b want 3 1 1111 0000",
                     seq_state, seq_locked, link_valid_seen, link_gate_reset);
        end
`ifdef RX_FSRC_SEQ_SKEW_CNT_EN
        checks++;
        if (link_lock_cycles !== {32'd9, 32'd7, 32'd5, 32'd3}) begin
            errors++;
            $display("FAIL lock_skew: got %0d,%0d,%0d,%0d want 9,7,5,3",
                     link_lock_cycles[3], link_lock_cycles[2],
                     link_lock_cycles[1], link_lock_cycles[0]);
        end
`endif
    endtask

    task automatic test_stop_from_locked;
        seq_stop = 1'b1;
        tick(1);
        seq_stop = 1'b0;
        checks++;
        if ({seq_state, fsrc_en, link_gate_reset, link_valid_seen} !== {3'd4, 1'b0, 4'hF, 4'hF}) begin
            errors++;
            $display("FAIL stop_enter: state=%0d en=%b gate=%b seen=%b want 4 0 1111 1111",
                     seq_state, fsrc_en, link_gate_reset, link_valid_seen);
        end
        tick(4);
        link_fsrc_valid = 4'h0;
        checks++;
        if ({seq_state, seq_busy} !== {3'd0, 1'b0}) begin
            errors++;
            $display("FAIL stop_idle: state=%0d busy=%b want 0 0", seq_state, seq_busy);
        end
    endtask

    task automatic test_timeout;
        timeout_cycles = 32'd10;
        link_fsrc_valid = 4'b0001;
        pulse_start(4'b0011);
        tick(4);
        tick(9);
        checks++;
        if (seq_state !== 3'd2) begin
            errors++;
            $display("FAIL timeout_early: state=%0d want 2", seq_state);
        end
        tick(1);
        checks++;
        if ({seq_state, seq_timeout, link_valid_seen, fsrc_en, link_gate_reset} !==
            {3'd5, 1'b1, 4'b0001, 1'b0, 4'hF}) begin
            errors++;
            $display("FAIL timeout_err: state=%0d to=%b seen=%b en=%b gate=%b want 5 1 0001 0 1111",
                     seq_state, seq_timeout, link_valid_seen, fsrc_en, link_gate_reset);
        end
    endtask

    task automatic test_lock_timeout_same;
        pulse_start(4'b0011);
        checks++;
        if ({seq_state, seq_timeout, link_valid_seen} !== {3'd1, 1'b0, 4'h0}) begin
            errors++;
            $display("FAIL retry_clear: state=%0d to=%b seen=%b want 1 0 0000",
                     seq_state, seq_timeout, link_valid_seen);
        end
        tick(4);
        tick(9);
        link_fsrc_valid = 4'b0011;
        tick(1);
        checks++;
        if ({seq_state, seq_locked, seq_timeout} !== {3'd3, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL lock_wins: state=%0d locked=%b to=%b want 3 1 0",
                     seq_state, seq_locked, seq_timeout);
        end
        seq_stop = 1'b1;
        tick(1);
        seq_stop = 1'b0;
        tick(4);
        link_fsrc_valid = 4'h0;
    endtask

    task automatic test_link_loss;
        timeout_cycles = 32'd0;
        pulse_start(4'b0100);
        tick(4);
        link_fsrc_valid = 4'b0100;
        tick(2);
        checks++;
        if ({seq_state, seq_locked} !== {3'd3, 1'b1}) begin
            errors++;
            $display("FAIL loss_locked: state=%0d locked=%b want 3 1", seq_state, seq_locked);
        end
        link_fsrc_valid = 4'h0;
        tick(1);
        checks++;
        if ({seq_state, seq_link_lost, fsrc_en, link_gate_reset} !== {3'd5, 1'b1, 1'b0, 4'hF}) begin
            errors++;
            $display("FAIL loss_err: state=%0d lost=%b en=%b gate=%b want 5 1 0 1111",
                     seq_state, seq_link_lost, fsrc_en, link_gate_reset);
        end
        pulse_start(4'b0100);
        checks++;
        if ({seq_state, seq_link_lost, seq_timeout, link_valid_seen} !== {3'd1, 1'b0, 1'b0, 4'h0}) begin
            errors++;
            $display("FAIL loss_retry: state=%0d lost=%b to=%b seen=%b want 1 0 0 0000",
                     seq_state, seq_link_lost, seq_timeout, link_valid_seen);
        end
    endtask

    task automatic test_stop_priority;
        tick(4);
        checks++;
        if (seq_state !== 3'd2) begin
            errors++;
            $display("FAIL prio_wait: state=%0d want 2", seq_state);
        end
        link_mask = 4'hF;
        seq_start = 1'b1;
        seq_stop = 1'b1;
        tick(1);
        seq_start = 1'b0;
        seq_stop = 1'b0;
        checks++;
        if ({seq_state, link_gate_reset, fsrc_en} !== {3'd4, 4'hF, 1'b0}) begin
            errors++;
            $display("FAIL prio_stop: state=%0d gate=%b en=%b want 4 1111 0",
                     seq_state, link_gate_reset, fsrc_en);
        end
        tick(3);
        checks++;
        if (seq_state !== 3'd4) begin
            errors++;
            $display("FAIL prio_stop_hold: state=%0d want 4", seq_state);
        end
        tick(1);
        checks++;
        if ({seq_state, seq_busy} !== {3'd0, 1'b0}) begin
            errors++;
            $display("FAIL prio_idle: state=%0d busy=%b want 0 0", seq_state, seq_busy);
        end
        pulse_start(4'h0);
        checks++;
        if ({seq_state, seq_busy} !== {3'd0, 1'b0}) begin
            errors++;
            $display("FAIL zero_mask: state=%0d busy=%b want 0 0", seq_state, seq_busy);
        end
        seq_stop = 1'b1;
        tick(1);
        seq_stop = 1'b0;
        checks++;
        if (seq_state !== 3'd0) begin
            errors++;
            $display("FAIL idle_stop: state=%0d want 0", seq_state);
        end
    endtask

    task automatic test_async_reset;
        pulse_start(4'b0001);
        tick(4);
        checks++;
        if ({seq_state, fsrc_en} !== {3'd2, 1'b1}) begin
            errors++;
            $display("FAIL areset_pre: state=%0d en=%b want 2 1", seq_state, fsrc_en);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({seq_state, fsrc_en, link_gate_reset, seq_busy} !== {3'd0, 1'b0, 4'hF, 1'b0}) begin
            errors++;
            $display("FAIL areset: state=%0d en=%b gate=%b busy=%b want 0 0 1111 0",
                     seq_state, fsrc_en, link_gate_reset, seq_busy);
        end
        tick(1);
        rst = 1'b0;
        tick(1);
        checks++;
        if (seq_state !== 3'd0) begin
            errors++;
            $display("FAIL areset_release: state=%0d want 0", seq_state);
        end
    endtask

    initial begin
        test_reset();
        test_basic_lock();
        test_stop_from_locked();
        test_timeout();
        test_lock_timeout_same();
        test_link_loss();
        test_stop_priority();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rx_fsrc_seq_ctrl.md
Name: rx_fsrc_seq_ctrl

Overview:
- Sequencer for the RX FSRC per-link wait-valid gates.
- Starts and stops FSRC capture across a masked set of links:
  - holds the per-link gate logic in reset;
  - asserts fsrc_en;
  - waits until every enabled link reports its first valid sample;
  - reports lock, timeout or link loss.
- Sits between the register map (pulse commands, status) and the per-link gate instances.
- All inputs are already synchronous to rx_glblclk.

Parameters:
- NUM_LINK, 4, number of RX links sequenced.
- TIMEOUT_WIDTH, 32, width of the timeout counter and timeout_cycles.
- ARM_DELAY, 4, cycles gate reset is held in ARM and in STOP; must be >= 1.

Ports:
- rx_glblclk  in  1  sequencer clock.
- rx_transport_reset_gc  in  1  reset; asynchronous assert, active-high.
- seq_start  in  1  single-cycle start or retry command.
- seq_stop  in  1  single-cycle stop command.
- link_mask  in  NUM_LINK  links to sequence; latched on accepted start.
- timeout_cycles  in  TIMEOUT_WIDTH  WAIT timeout in cycles; 0 disables the timeout.
- link_fsrc_valid  in  NUM_LINK  per-link gate "valid seen" flag.
- fsrc_en  out  1  FSRC gating enable to all links.
- link_gate_reset  out  NUM_LINK  per-link gate reset, active-high.
- seq_busy  out  1  state is not IDLE.
- seq_locked  out  1  state is LOCKED.
- seq_timeout  out  1  sticky; WAIT timed out.
- seq_link_lost  out  1  sticky; a masked link's valid flag fell while LOCKED.
- link_valid_seen  out  NUM_LINK  sticky per-link first-valid record.
- seq_state  out  3  current state encoding.

Behaviour:
- All outputs are registered.
- Reset values:
  - state IDLE, fsrc_en 0;
  - link_gate_reset all ones;
  - all status bits 0;
  - latched mask 0, counters 0.
- State encodings: IDLE=0, ARM=1, WAIT=2, LOCKED=3, STOP=4, ERROR=5.
- IDLE:
  - fsrc_en=0; link_gate_reset all ones.
  - seq_start with link_mask!=0 in cycle N:
    - latches the mask;
    - clears seq_timeout, seq_link_lost and link_valid_seen;
    - state=ARM at N+1.
  - seq_start with link_mask==0 is ignored.
- ARM:
  - gate reset held all ones; delay counter counts ARM_DELAY cycles.
  - Then enter WAIT.
  - On WAIT entry: link_gate_reset = ~mask_l, fsrc_en=1, timeout counter cleared.
- WAIT:
  - Each cycle: link_valid_seen |= link_fsrc_valid & mask_l; timeout counter +1.
  - If (link_valid_seen | (link_fsrc_valid & mask_l)) == mask_l → LOCKED next cycle.
  - Otherwise, if timeout_cycles!=0 and counter == timeout_cycles-1 → ERROR; seq_timeout=1.
  - Lock and timeout in the same cycle: lock wins.
  - Counter saturates at its maximum; it never wraps.
- LOCKED:
  - Any masked link with link_fsrc_valid == 0 → ERROR; seq_link_lost=1.
  - ERROR entry: fsrc_en=0; link_gate_reset all ones.
- ERROR:
  - Holds until a command arrives.
  - seq_start → ARM, same latch/clear actions as from IDLE; link_mask==0 is ignored.
  - seq_stop → STOP.
- STOP:
  - fsrc_en=0; link_gate_reset all ones.
  - Hold ARM_DELAY cycles, then IDLE.
  - Stickies are preserved.
- Command priority and acceptance:
  - seq_stop is accepted in ARM/WAIT/LOCKED/ERROR; it is ignored in IDLE and STOP.
  - seq_stop beats seq_start in the same cycle.
  - seq_start is ignored in ARM/WAIT/LOCKED/STOP.
- link_mask changes after the latch have no effect until the next accepted start.
- Reset asserted mid-sequence: immediate return to reset values; there is no draining.

Optional Feature:
- Macro: RX_FSRC_SEQ_SKEW_CNT_EN.
- Defined:
  - adds output link_lock_cycles, NUM_LINK x TIMEOUT_WIDTH.
  - Each entry captures the WAIT timeout counter value in the cycle that link's link_valid_seen bit first sets.
  - Entries are cleared on accepted start and hold until the next accepted start.
  - Unmasked links read 0.
- Undefined: the port and its registers are absent; all other behaviour is identical.

Decomposition:
- Package rx_fsrc_seq_pkg:
  - state enum and SEQ_STATE_W=3;
  - default TIMEOUT_WIDTH and ARM_DELAY constants.
- Sub-module rx_fsrc_seq_link_tracker, one per link:
  - sticky seen bit;
  - loss detection while LOCKED;
  - optional skew capture register.
- The FSM, counters and command handling stay in the top module.

Test Plan:
- Basic lock:
  - Stimulus: mask=4'b1111, timeout=100, ARM_DELAY=4, start; links assert valid at WAIT cycles 3,5,7,9.
  - Required: fsrc_en rises 5 cycles after start; seq_locked one cycle after the 4th valid; with skew enabled, link_lock_cycles = {9,7,5,3}.
- Timeout:
  - Stimulus: mask=4'b0011, timeout=10, only link0 valid.
  - Required: ERROR exactly 10 cycles after WAIT entry; seq_timeout=1; link_valid_seen=4'b0001; fsrc_en=0.
- Lock/timeout same cycle:
  - Stimulus: last valid arrives in the timeout cycle.
  - Required: LOCKED, seq_timeout=0.
- Link loss:
  - Stimulus: in LOCKED, drop link2 valid with mask=4'b0100.
  - Required: ERROR next cycle, seq_link_lost=1; a following start clears both stickies and re-enters ARM.
- Stop and priority:
  - Stimulus: start and stop in the same cycle from WAIT.
  - Required: STOP, link_gate_reset=4'b1111, IDLE after 4 cycles. Separately, start with mask=0 in IDLE leaves seq_busy=0.
- Async reset:
  - Stimulus: reset asserted mid-WAIT, between clock edges.
  - Required: fsrc_en=0 and link_gate_reset=4'b1111 immediately, state IDLE.
